// File: rtl/vseq_pkg.sv
// Shared types and constants for the vector-store sequencer.
package vseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } vseq_state_e;

  localparam int unsigned VSEQ_LANES      = 5;
  localparam int unsigned VSEQ_WORD_BYTES = 4;

endpackage

// File: rtl/vseq_lane_pick.sv
// Combinational lowest-set-bit finder: index of the lowest set bit plus an any-set flag.
module vseq_lane_pick #(
  parameter int unsigned LANES = 5,
  parameter int unsigned IW    = 3
) (
  input  logic [LANES-1:0] vec_i,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = LANES; i > 0; i--) begin
      if (vec_i[i-1]) begin
        idx_o = IW'(i - 1);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_store_seq.sv
// Breaks one vector store into sequential scalar word writes, lowest lane first.
// Define VSEQ_MASK_EN to honour req_mask; otherwise every lane is written.
module vec_store_seq
  import vseq_pkg::*;
#(
  parameter int unsigned LANES = VSEQ_LANES,
  parameter int unsigned DW    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DW-1:0]      req_addr,
  input  logic [LANES*DW-1:0] req_data,
  input  logic [LANES-1:0]   req_mask,
  output logic               MemWrite,
  output logic [DW-1:0]      DataAdr,
  output logic [DW-1:0]      WriteData,
  input  logic               mem_ready,
  output logic               done
);

  localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

  vseq_state_e         state_q, state_d;
  logic [DW-1:0]       addr_q, addr_d;
  logic [LANES*DW-1:0] data_q, data_d;
  logic [LANES-1:0]    pend_q, pend_d;
  logic [LANES-1:0]    mask_in;
  logic [LANES-1:0]    lane_bit;
  logic [IW-1:0]       lane_idx;
  logic                lane_any;
  int unsigned         lane_int;

`ifdef VSEQ_MASK_EN
  assign mask_in = req_mask;
`else
  // Mask is forced to all-ones; OR keeps the port referenced.
  assign mask_in = req_mask | {LANES{1'b1}};
`endif

  vseq_lane_pick #(
    .LANES (LANES),
    .IW    (IW)
  ) u_pick (
    .vec_i (pend_q),
    .idx_o (lane_idx),
    .any_o (lane_any)
  );

  assign lane_bit = LANES'(1) << lane_idx;
  assign lane_int = 32'(lane_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          pend_d  = mask_in;
          state_d = (|mask_in) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (!lane_any) begin
          state_d = DONE;
        end else if (mem_ready) begin
          pend_d = pend_q & ~lane_bit;
          if (pend_d == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    done      = (state_q == DONE);
    MemWrite  = (state_q == ISSUE) && lane_any;
    DataAdr   = '0;
    WriteData = '0;
    if (MemWrite) begin
      DataAdr   = (addr_q & ~DW'(VSEQ_WORD_BYTES - 1))
                + DW'(lane_idx) * DW'(VSEQ_WORD_BYTES);
      WriteData = data_q[lane_int*DW +: DW];
    end
  end

endmodule

// File: tb/tb_vec_store_seq.sv
// Directed self-checking bench for vec_store_seq (default 5 lanes x 32 bits).
module tb_vec_store_seq;

  localparam logic [159:0] LANE_DATA = {32'd11, 32'd10, 32'd9, 32'd8, 32'd7};

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [159:0] req_data;
  logic [4:0]   req_mask;
  logic         MemWrite;
  logic [31:0]  DataAdr;
  logic [31:0]  WriteData;
  logic         mem_ready;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] lg_addr [32];
  logic [31:0] lg_data [32];
  int          lg_cyc  [32];
  logic        lg_rdy  [32];
  int          lg_n;
  int          done_cyc;

  vec_store_seq #(.LANES(5), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .mem_ready (mem_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and log every MemWrite cycle until done (or budget runs out).
  // stall_n: cycles mem_ready is held low while lane 1 (data 8) is presented.
  // noise: keep req_valid high with a different request while busy.
  task automatic run_store(input logic [31:0] base, input logic [4:0] mask,
                           input int stall_n, input bit noise);
    int stall_left;
    int cyc;
    stall_left = stall_n;
    lg_n       = 0;
    done_cyc   = -1;
    req_addr   = base;
    req_data   = LANE_DATA;
    req_mask   = mask;
    req_valid  = 1'b1;
    mem_ready  = 1'b1;
    @(posedge clk); #1;
    req_valid = noise;
    if (noise) begin
      req_addr = 32'h200;
      req_data = '1;
      req_mask = 5'b00001;
    end
    cyc = 1;
    while (cyc <= 30 && done_cyc < 0) begin
      mem_ready = 1'b1;
      if (MemWrite) begin
        if (WriteData == 32'd8 && stall_left > 0) begin
          mem_ready = 1'b0;
          stall_left--;
        end
        if (lg_n < 32) begin
          lg_addr[lg_n] = DataAdr;
          lg_data[lg_n] = WriteData;
          lg_cyc[lg_n]  = cyc;
          lg_rdy[lg_n]  = mem_ready;
          lg_n++;
        end
      end
      if (done) done_cyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    mem_ready = 1'b1;
    if (done_cyc < 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("ready_after_done", 32'(req_ready), 32'd1);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_no_write", 32'(MemWrite), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ea [5];
    logic [31:0] ed [5];
    ed = '{32'd7, 32'd8, 32'd9, 32'd10, 32'd11};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_mask  = '0;
    mem_ready = 1'b1;
    #12;
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_dataadr", DataAdr, 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd1);

    // Full store, with a competing request held valid while busy
    run_store(32'h60, 5'b11111, 0, 1'b1);
    ea = '{32'h60, 32'h64, 32'h68, 32'h6C, 32'h70};
    check("full_nwr", lg_n, 5);
    for (int i = 0; i < 5 && i < lg_n; i++) begin
      check($sformatf("full_adr%0d", i), lg_addr[i], ea[i]);
      check($sformatf("full_dat%0d", i), lg_data[i], ed[i]);
      check($sformatf("full_cyc%0d", i), lg_cyc[i], i + 1);
    end
    check("full_done", done_cyc, 6);

    // Sparse mask
    run_store(32'h60, 5'b00101, 0, 1'b0);
`ifdef VSEQ_MASK_EN
    check("mask_nwr", lg_n, 2);
    check("mask_adr0", lg_addr[0], 32'h60);
    check("mask_dat0", lg_data[0], 32'd7);
    check("mask_adr1", lg_addr[1], 32'h68);
    check("mask_dat1", lg_data[1], 32'd9);
    check("mask_done", done_cyc, 3);
`else
    check("mask_nwr", lg_n, 5);
    for (int i = 0; i < 5 && i < lg_n; i++) begin
      check($sformatf("mask_adr%0d", i), lg_addr[i], ea[i]);
      check($sformatf("mask_dat%0d", i), lg_data[i], ed[i]);
    end
    check("mask_done", done_cyc, 6);
`endif

    // Back-pressure on lane 1 for 3 cycles
    run_store(32'h60, 5'b11111, 3, 1'b0);
    check("stall_nlog", lg_n, 8);
    for (int i = 1; i <= 4 && i < lg_n; i++) begin
      check($sformatf("stall_adr%0d", i), lg_addr[i], 32'h64);
      check($sformatf("stall_dat%0d", i), lg_data[i], 32'd8);
      check($sformatf("stall_rdy%0d", i), 32'(lg_rdy[i]), (i == 4) ? 32'd1 : 32'd0);
    end
    if (lg_n >= 8) begin
      check("stall_adr5", lg_addr[5], 32'h68);
      check("stall_adr7", lg_addr[7], 32'h70);
      check("stall_dat7", lg_data[7], 32'd11);
    end
    check("stall_done", done_cyc, 9);

    // Empty mask
    run_store(32'h60, 5'b00000, 0, 1'b0);
`ifdef VSEQ_MASK_EN
    check("zero_nwr", lg_n, 0);
    check("zero_done", done_cyc, 1);
`else
    check("zero_nwr", lg_n, 5);
    check("zero_done", done_cyc, 6);
`endif

    // Reset during lane 2
    req_addr  = 32'h60;
    req_data  = LANE_DATA;
    req_mask  = 5'b11111;
    req_valid = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_adr", DataAdr, 32'h68);
    check("abort_pre_mw", 32'(MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_mw", 32'(MemWrite), 32'd0);
    check("abort_adr", DataAdr, 32'd0);
    check("abort_wd", WriteData, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort_quiet_mw%0d", i), 32'(MemWrite), 32'd0);
      check($sformatf("abort_quiet_done%0d", i), 32'(done), 32'd0);
    end
    check("abort_ready", 32'(req_ready), 32'd1);
    run_store(32'h100, 5'b11111, 0, 1'b0);
    check("post_abort_adr0", lg_addr[0], 32'h100);
    check("post_abort_dat0", lg_data[0], 32'd7);
    check("post_abort_adr4", lg_addr[4], 32'h110);
    check("post_abort_done", done_cyc, 6);

    // Address wrap-around
    run_store(32'hFFFF_FFF8, 5'b11111, 0, 1'b0);
    ea = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    check("wrap_nwr", lg_n, 5);
    for (int i = 0; i < 5 && i < lg_n; i++) begin
      check($sformatf("wrap_adr%0d", i), lg_addr[i], ea[i]);
    end

    // Unaligned base is word-aligned on output
    run_store(32'h63, 5'b11111, 0, 1'b0);
    check("unal_adr0", lg_addr[0], 32'h60);
    check("unal_adr1", lg_addr[1], 32'h64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
